idx_rd_ctrl: RTL and testbench

Read-side sequencer for the PE index buffer. The index buffer is loaded through idx_wr_data/idx_wr_addr/idx_wr_en, one byte per entry packed {idx_y[7:4], idx_x[3:0]}.
- On start, the block replays entries 0..idx_cnt, (trip_cnt+1) times.
- Each entry is unpacked into x/y coordinates with padding flags.
- Entries are delivered over a valid/ready stream to the PE datapath.
- Sits between the index RAM read port and the PE address generators.

---
 rtl/idx_rd_ctrl.sv | 265 ++++++++++++++++++++++++++
 tb/tb_idx_rd_ctrl.sv | 321 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/idx_rd_ctrl.sv
// -----------------------------------------------------------------------------
// idx_rd_ctrl -- read-side sequencer for the PE index buffer.
//
// Replays index RAM entries 0..idx_cnt, (trip_cnt+1) times, after a start
// pulse. Each byte read from the RAM is unpacked into {y[7:4], x[3:0]}, tagged
// with a padding flag and last-entry / last-pass markers, and delivered over a
// valid/ready stream through a 2-entry output FIFO. Reads are issued under
// credit control so the FIFO can never overflow.
//
// Optional feature (compile-time macro IDX_RD_PERF_EN):
//   adds output stall_cnt[15:0], a saturating count of cycles with
//   out_valid=1 and out_ready=0; cleared on reset and on an accepted start.
//
// Ports:
//   clk            clock, rising edge
//   rst            asynchronous active-low reset
//   start          one-cycle pulse, latches idx_cnt/trip_cnt/pad_code (IDLE only)
//   done           one-cycle pulse the cycle after the final beat handshakes
//   busy           high from the cycle after an accepted start until done
//   idx_cnt        number of entries minus 1
//   trip_cnt       number of passes minus 1
//   pad_code       bit0 left, bit1 right, bit2 top, bit3 bottom
//   idx_rd_en      index RAM read enable
//   idx_rd_addr    index RAM read address
//   idx_rd_data    RAM data, valid the cycle after idx_rd_en
//   out_valid/out_ready   output stream handshake
//   out_x, out_y   unpacked coordinates
//   out_pad        coordinate lies on an enabled padded edge
//   out_last_idx   beat is entry idx_cnt of its pass
//   out_last_trip  beat belongs to the final pass
// -----------------------------------------------------------------------------
module idx_rd_ctrl #(
    parameter  int IDX_DEPTH = 256,
    localparam int ADDR_W    = $clog2(IDX_DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic              done,
    output logic              busy,
    input  logic [7:0]        idx_cnt,
    input  logic [7:0]        trip_cnt,
    input  logic [3:0]        pad_code,
    output logic              idx_rd_en,
    output logic [ADDR_W-1:0] idx_rd_addr,
    input  logic [7:0]        idx_rd_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [3:0]        out_x,
    output logic [3:0]        out_y,
    output logic              out_pad,
    output logic              out_last_idx,
    output logic              out_last_trip
`ifdef IDX_RD_PERF_EN
    ,
    output logic [15:0]       stall_cnt
`endif
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    typedef struct packed {
        logic [3:0] x;
        logic [3:0] y;
        logic       pad;
        logic       last_idx;
        logic       last_trip;
    } beat_t;

    state_t     state_q, state_d;
    logic [7:0] idx_cnt_q, idx_cnt_d;
    logic [7:0] trip_cnt_q, trip_cnt_d;
    logic [3:0] pad_code_q, pad_code_d;
    logic [7:0] addr_cnt_q, addr_cnt_d;
    logic [7:0] trip_ctr_q, trip_ctr_d;

    // One read may be in flight; its last flags are tagged at issue time and
    // travel alongside until the data is captured into the FIFO.
    logic       inf_vld_q, inf_vld_d;
    logic       inf_li_q, inf_li_d;
    logic       inf_lt_q, inf_lt_d;

    beat_t      fifo_q [2];
    beat_t      fifo_d [2];
    logic       wr_ptr_q, wr_ptr_d;
    logic       rd_ptr_q, rd_ptr_d;
    logic [1:0] count_q, count_d;

    logic       done_q, done_d;

    beat_t      head;
    logic       fifo_vld;
    logic       pop;
    logic       push;
    logic       credit_ok;
    logic       issue;
    logic [2:0] credit_use;
    logic [3:0] cap_x;
    logic [3:0] cap_y;
    logic       cap_pad;

    assign head     = fifo_q[rd_ptr_q];
    assign fifo_vld = (count_q != 2'd0);
    assign pop      = fifo_vld & out_ready;
    assign push     = inf_vld_q;

    // Slots already committed (stored + in flight), minus the one leaving now.
    // pop implies count_q >= 1, so this never underflows.
    assign credit_use = {1'b0, count_q} + {2'b00, inf_vld_q} - {2'b00, pop};
    assign credit_ok  = (credit_use < 3'd2);
    assign issue      = (state_q == S_RUN) & credit_ok;

    assign cap_x   = idx_rd_data[3:0];
    assign cap_y   = idx_rd_data[7:4];
    assign cap_pad = (pad_code_q[0] & (cap_x == 4'd0))  |
                     (pad_code_q[1] & (cap_x == 4'd15)) |
                     (pad_code_q[2] & (cap_y == 4'd0))  |
                     (pad_code_q[3] & (cap_y == 4'd15));

    // Sequencer, in-flight tracking and FIFO next-state.
    always_comb begin
        state_d    = state_q;
        idx_cnt_d  = idx_cnt_q;
        trip_cnt_d = trip_cnt_q;
        pad_code_d = pad_code_q;
        addr_cnt_d = addr_cnt_q;
        trip_ctr_d = trip_ctr_q;
        done_d     = 1'b0;
        fifo_d     = fifo_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;

        inf_vld_d  = issue;
        inf_li_d   = issue & (addr_cnt_q == idx_cnt_q);
        inf_lt_d   = issue & (trip_ctr_q == trip_cnt_q);

        if (push) begin
            fifo_d[wr_ptr_q] = '{x: cap_x, y: cap_y, pad: cap_pad,
                                 last_idx: inf_li_q, last_trip: inf_lt_q};
            wr_ptr_d = ~wr_ptr_q;
        end
        if (pop) begin
            rd_ptr_d = ~rd_ptr_q;
        end
        count_d = count_q + {1'b0, push} - {1'b0, pop};

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    idx_cnt_d  = idx_cnt;
                    trip_cnt_d = trip_cnt;
                    pad_code_d = pad_code;
                    addr_cnt_d = 8'd0;
                    trip_ctr_d = 8'd0;
                    state_d    = S_RUN;
                end
            end
            S_RUN: begin
                if (issue) begin
                    if (addr_cnt_q == idx_cnt_q) begin
                        if (trip_ctr_q == trip_cnt_q) begin
                            state_d = S_DRAIN;
                        end else begin
                            addr_cnt_d = 8'd0;
                            trip_ctr_d = trip_ctr_q + 8'd1;
                        end
                    end else begin
                        addr_cnt_d = addr_cnt_q + 8'd1;
                    end
                end
            end
            S_DRAIN: begin
                // The final beat is the only one carrying both last flags;
                // once it leaves, nothing else can be stored or in flight.
                if (pop && head.last_idx && head.last_trip &&
                    (count_d == 2'd0) && !inf_vld_q) begin
                    done_d  = 1'b1;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= S_IDLE;
            idx_cnt_q  <= '0;
            trip_cnt_q <= '0;
            pad_code_q <= '0;
            addr_cnt_q <= '0;
            trip_ctr_q <= '0;
            inf_vld_q  <= 1'b0;
            inf_li_q   <= 1'b0;
            inf_lt_q   <= 1'b0;
            wr_ptr_q   <= 1'b0;
            rd_ptr_q   <= 1'b0;
            count_q    <= '0;
            done_q     <= 1'b0;
            for (int i = 0; i < 2; i++) begin
                fifo_q[i] <= '0;
            end
        end else begin
            state_q    <= state_d;
            idx_cnt_q  <= idx_cnt_d;
            trip_cnt_q <= trip_cnt_d;
            pad_code_q <= pad_code_d;
            addr_cnt_q <= addr_cnt_d;
            trip_ctr_q <= trip_ctr_d;
            inf_vld_q  <= inf_vld_d;
            inf_li_q   <= inf_li_d;
            inf_lt_q   <= inf_lt_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            done_q     <= done_d;
            for (int i = 0; i < 2; i++) begin
                fifo_q[i] <= fifo_d[i];
            end
        end
    end

    // Address wraps modulo the RAM depth.
    assign idx_rd_en   = issue;
    assign idx_rd_addr = issue ? ADDR_W'(addr_cnt_q) : '0;

    assign done = done_q;
    assign busy = (state_q != S_IDLE);

    // Fields are forced to zero when no beat is presented.
    assign out_valid     = fifo_vld;
    assign out_x         = fifo_vld ? head.x         : 4'd0;
    assign out_y         = fifo_vld ? head.y         : 4'd0;
    assign out_pad       = fifo_vld & head.pad;
    assign out_last_idx  = fifo_vld & head.last_idx;
    assign out_last_trip = fifo_vld & head.last_trip;

`ifdef IDX_RD_PERF_EN
    logic [15:0] stall_cnt_q, stall_cnt_d;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if ((state_q == S_IDLE) && start) begin
            stall_cnt_d = 16'd0;
        end else if (fifo_vld && !out_ready && (stall_cnt_q != 16'hFFFF)) begin
            stall_cnt_d = stall_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_idx_rd_ctrl.sv
// -----------------------------------------------------------------------------
// Testbench for idx_rd_ctrl. A behavioural index RAM (1-cycle read latency)
// feeds the DUT. Stimulus pushes the expected beat sequence into a scoreboard
// queue; an independent monitor pops and compares on every output handshake,
// and also watches credit usage, stall stability and done timing.
// -----------------------------------------------------------------------------
module tb_idx_rd_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        done;
    logic        busy;
    logic [7:0]  idx_cnt;
    logic [7:0]  trip_cnt;
    logic [3:0]  pad_code;
    logic        idx_rd_en;
    logic [7:0]  idx_rd_addr;
    logic [7:0]  idx_rd_data;
    logic        out_valid;
    logic        out_ready;
    logic [3:0]  out_x;
    logic [3:0]  out_y;
    logic        out_pad;
    logic        out_last_idx;
    logic        out_last_trip;
`ifdef IDX_RD_PERF_EN
    logic [15:0] stall_cnt;
`endif

    idx_rd_ctrl #(.IDX_DEPTH(256)) dut (
        .clk           (clk),
        .rst           (rst),
        .start         (start),
        .done          (done),
        .busy          (busy),
        .idx_cnt       (idx_cnt),
        .trip_cnt      (trip_cnt),
        .pad_code      (pad_code),
        .idx_rd_en     (idx_rd_en),
        .idx_rd_addr   (idx_rd_addr),
        .idx_rd_data   (idx_rd_data),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_x         (out_x),
        .out_y         (out_y),
        .out_pad       (out_pad),
        .out_last_idx  (out_last_idx),
        .out_last_trip (out_last_trip)
`ifdef IDX_RD_PERF_EN
        ,
        .stall_cnt     (stall_cnt)
`endif
    );

    always #5 clk = ~clk;

    // Index RAM model
    logic [7:0] mem [256];
    always @(posedge clk) begin
        if (idx_rd_en) idx_rd_data <= mem[idx_rd_addr];
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // out_ready driver: 0 = hold 1, 1 = hold 0, 2 = pseudo-random
    int ready_mode = 0;
    initial begin
        out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (ready_mode)
                0:       out_ready = 1'b1;
                1:       out_ready = 1'b0;
                default: out_ready = 1'($urandom_range(0, 1));
            endcase
        end
    end

    typedef struct packed {
        logic [3:0] x;
        logic [3:0] y;
        logic       pad;
        logic       li;
        logic       lt;
    } beat_t;

    beat_t exp_q[$];
    int    checks = 0;
    int    errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor state
    bit    mon_en = 1'b0;
    bit    lat_chk = 1'b0;
    int    outstanding = 0;
    bit    stalled_prev = 1'b0;
    beat_t held;
    int    beat_cnt = 0;
    int    start_cyc = 0;
    int    prev_beat_cyc = 0;
    int    last_hs_cyc = -10;
    int    done_cnt = 0;

    initial begin
        beat_t cur;
        beat_t e;
        int    pop;
        forever begin
            @(negedge clk);
            if (!rst || !mon_en) begin
                outstanding  = 0;
                stalled_prev = 1'b0;
            end else begin
                pop = (out_valid && out_ready) ? 1 : 0;
                cur = {out_x, out_y, out_pad, out_last_idx, out_last_trip};
                if (idx_rd_en) check("credit", 32'((outstanding - pop) < 2), 32'd1);
                outstanding = outstanding + (idx_rd_en ? 1 : 0) - pop;
                if (stalled_prev) begin
                    check("stall_valid", 32'(out_valid), 32'd1);
                    check("stall_fields", 32'(cur), 32'(held));
                end
                stalled_prev = out_valid && !out_ready;
                held = cur;
                if (pop != 0) begin
                    if (exp_q.size() == 0) begin
                        check("extra_beat", 32'(exp_q.size()), 32'd1);
                    end else begin
                        e = exp_q.pop_front();
                        check("beat", 32'(cur), 32'(e));
                    end
                    if (ready_mode == 0) begin
                        if (beat_cnt == 0) begin
                            if (lat_chk) check("first_lat", cyc - start_cyc, 32'd3);
                        end else begin
                            check("no_bubble", cyc - prev_beat_cyc, 32'd1);
                        end
                    end
                    prev_beat_cyc = cyc;
                    beat_cnt++;
                    if (cur.li && cur.lt) last_hs_cyc = cyc;
                end
                if (done) begin
                    done_cnt++;
                    check("done_timing", cyc - last_hs_cyc, 32'd1);
                    check("busy_at_done", 32'(busy), 32'd0);
                end
            end
        end
    end

    function automatic logic exp_pad(input logic [3:0] pc, input int i);
        case (pc)
            4'b0101: return (i == 0);              // left x==0 | top y==0
            4'b1010: return (i == 1) || (i == 15); // right x==15 | bottom y==15
            default: return 1'b0;
        endcase
    endfunction

    task automatic push_job(input int ni, input int nt, input logic [3:0] pc);
        beat_t e;
        for (int t = 0; t <= nt; t++) begin
            for (int i = 0; i <= ni; i++) begin
                e.x   = 4'(i);
                e.y   = 4'(16 - i);
                e.pad = exp_pad(pc, i);
                e.li  = (i == ni);
                e.lt  = (t == nt);
                exp_q.push_back(e);
            end
        end
    endtask

    task automatic start_job(input int ni, input int nt, input logic [3:0] pc, input bit chk_lat);
        @(posedge clk);
        #1;
        idx_cnt   = 8'(ni);
        trip_cnt  = 8'(nt);
        pad_code  = pc;
        start     = 1'b1;
        start_cyc = cyc;
        beat_cnt  = 0;
        lat_chk   = chk_lat;
        @(posedge clk);
        #1;
        start = 1'b0;
        check("busy_run", 32'(busy), 32'd1);
    endtask

    task automatic wait_done(input int budget, input int nbeats);
        bit got;
        got = 1'b0;
        for (int i = 0; i < budget && !got; i++) begin
            @(negedge clk);
            if (done) got = 1'b1;
        end
        check("done_seen", 32'(got), 32'd1);
        check("beat_count", beat_cnt, nbeats);
        check("queue_empty", 32'(exp_q.size()), 32'd0);
        @(negedge clk);
        check("busy_after", 32'(busy), 32'd0);
        check("done_pulse", 32'(done), 32'd0);
        $display("job done: idx_cnt=%0d trip_cnt=%0d beats=%0d", idx_cnt, trip_cnt, beat_cnt);
    endtask

    initial begin
        bit any_bad;
        rst      = 1'b0;
        start    = 1'b0;
        idx_cnt  = 8'd0;
        trip_cnt = 8'd0;
        pad_code = 4'd0;
        for (int i = 0; i < 256; i++) begin
            mem[i] = (i < 16) ? {4'(16 - i), 4'(i)} : 8'(i);
        end

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("reset_outs", 32'({done, busy, idx_rd_en, idx_rd_addr, out_valid, out_x,
                                 out_y, out_pad, out_last_idx, out_last_trip}), 32'd0);
`ifdef IDX_RD_PERF_EN
        check("reset_stall_cnt", 32'(stall_cnt), 32'd0);
`endif
        rst    = 1'b1;
        mon_en = 1'b1;

        // 1: full job, ready held high
        push_job(15, 3, 4'b0000);
        start_job(15, 3, 4'b0000, 1'b1);
        wait_done(300, 64);

        // 2: same job with random backpressure
        ready_mode = 2;
        push_job(15, 3, 4'b0000);
        start_job(15, 3, 4'b0000, 1'b0);
        wait_done(1000, 64);
        ready_mode = 0;

        // 3: single-entry, single-pass job
        push_job(0, 0, 4'b0000);
        start_job(0, 0, 4'b0000, 1'b1);
        wait_done(20, 1);

        // 4: pad flags
        push_job(15, 3, 4'b0101);
        start_job(15, 3, 4'b0101, 1'b1);
        wait_done(300, 64);
        push_job(15, 0, 4'b1010);
        start_job(15, 0, 4'b1010, 1'b1);
        wait_done(100, 16);

        // 5a: start pulse mid-job is ignored
        push_job(15, 3, 4'b0000);
        start_job(15, 3, 4'b0000, 1'b1);
        repeat (5) @(posedge clk);
        #1;
        idx_cnt  = 8'd3;
        trip_cnt = 8'd0;
        start    = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_done(300, 64);

        // 5b: reset at beat 20 aborts the job without done
        push_job(15, 3, 4'b0000);
        start_job(15, 3, 4'b0000, 1'b1);
        for (int i = 0; i < 200 && beat_cnt < 20; i++) @(negedge clk);
        check("reached_beat20", beat_cnt, 32'd20);
        #2;
        mon_en = 1'b0;
        rst    = 1'b0;
        #1;
        check("abort_outs", 32'({done, busy, idx_rd_en, idx_rd_addr, out_valid, out_x,
                                 out_y, out_pad, out_last_idx, out_last_trip}), 32'd0);
        exp_q.delete();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        any_bad = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (done || busy || out_valid) any_bad = 1'b1;
        end
        check("no_done_after_abort", 32'(any_bad), 32'd0);
        mon_en = 1'b1;
        push_job(3, 1, 4'b0000);
        start_job(3, 1, 4'b0000, 1'b1);
        wait_done(100, 8);

        // 6: 10 stalled cycles from the first out_valid
        ready_mode = 1;
        @(posedge clk);
        push_job(3, 0, 4'b0000);
        start_job(3, 0, 4'b0000, 1'b0);
        for (int i = 0; i < 20 && !out_valid; i++) @(negedge clk);
        check("first_valid_lat", cyc - start_cyc, 32'd3);
        repeat (10) @(posedge clk);
        ready_mode = 0;
        wait_done(100, 4);
`ifdef IDX_RD_PERF_EN
        check("stall_cnt", 32'(stall_cnt), 32'd10);
        @(negedge clk);
        check("stall_cnt_hold", 32'(stall_cnt), 32'd10);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
